// File: rtl/polaris_ifetch.sv
// -----------------------------------------------------------------------------
// polaris_ifetch -- instruction-fetch front end for the Polaris RV64 core.
//
// A prefetching I-bus master fills a DEPTH-entry instruction queue. The
// consumer pops entries from the queue head. A redirect (jump or trap) flushes
// the queue and restarts fetch at the new target. A bus timeout or a
// misaligned redirect halts fetch with a sticky, cause-coded fault. Only
// reset clears the fault.
//
// Handshakes:
//   I-bus    : the request is isiz_o=2'b10 at address iadr_o. The bus may
//              hold it off for any number of cycles. The word transfers on a
//              rising edge where isiz_o=2'b10 and iack_i=1, with data on
//              idat_i. The address stays stable until that edge.
//   Consumer : valid_o/inst_o/pc_o present the queue head. The head is popped
//              on a rising edge where valid_o=1 and ready_i=1. inst_o and pc_o
//              are meaningless while valid_o=0.
//
// Ports:
//   clk_i          in   1         system clock, rising edge
//   reset_ni       in   1         asynchronous active-low reset
//   iadr_o         out  AW        I-bus fetch address (current fetch PC)
//   isiz_o         out  2         00 idle, 10 32-bit read request
//   iack_i         in   1         I-bus acknowledge
//   idat_i         in   32        I-bus read data, valid with iack_i
//   inst_o         out  32        instruction at the queue head
//   pc_o           out  AW        address of inst_o
//   valid_o        out  1         queue head valid
//   ready_i        in   1         consumer accepts the head
//   redirect_i     in   1         flush the queue, restart fetch at redirect_pc_i
//   redirect_pc_i  in   AW        redirect target (must be word aligned)
//   count_o        out  log2(D)+1 queue occupancy
//   fault_o        out  1         sticky fault, fetch halted
//   fault_cause_o  out  2         00 none, 01 bus timeout, 10 misaligned redirect
// -----------------------------------------------------------------------------
module polaris_ifetch #(
  parameter int          AW           = 64,
  parameter int          DEPTH        = 4,
  parameter logic [63:0] RESET_VECTOR = 64'hFFFF_FFFF_FFFF_FF00,
  parameter int          MAX_WAIT     = 0
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  output logic [AW-1:0]            iadr_o,
  output logic [1:0]               isiz_o,
  input  logic                     iack_i,
  input  logic [31:0]              idat_i,
  output logic [31:0]              inst_o,
  output logic [AW-1:0]            pc_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  input  logic                     redirect_i,
  input  logic [AW-1:0]            redirect_pc_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     fault_o,
  output logic [1:0]               fault_cause_o
);

  localparam int PW = $clog2(DEPTH);
  // Wide enough to hold MAX_WAIT itself; one bit minimum when timeout is off.
  localparam int WW = $clog2(MAX_WAIT + 2);

  localparam logic [AW-1:0] RV   = RESET_VECTOR[AW-1:0];
  localparam logic [WW-1:0] MW   = WW'(MAX_WAIT);
  localparam logic [PW:0]   FULL = (PW+1)'(DEPTH);

  localparam logic [1:0] SIZ_IDLE   = 2'b00;
  localparam logic [1:0] SIZ_WORD   = 2'b10;
  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_TMO  = 2'b01;
  localparam logic [1:0] CAUSE_MIS  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  // The whole control state sits in one struct, so checkers can bind to
  // r_ctl and see the FSM, the latched cause and the wait counter together.
  typedef struct packed {
    state_e        fsm;
    logic [1:0]    cause;
    logic [WW-1:0] wcnt;
  } ctl_t;

  ctl_t r_ctl;
  ctl_t w_ctl_nxt;

  // Fetch PC and queue bookkeeping.
  logic [AW-1:0] r_fpc;
  logic [PW-1:0] r_rptr;
  logic [PW-1:0] r_wptr;
  logic [PW:0]   r_count;

  // Queue storage. Entries are only read while valid, so there is no reset.
  logic [31:0]   r_inst_mem [DEPTH];
  logic [AW-1:0] r_pc_mem   [DEPTH];

  // Per-cycle datapath controls produced by the FSM process.
  logic          w_req;
  logic          w_push;
  logic          w_pop;
  logic          w_flush;
  logic          w_load_redir;
  logic          w_not_empty;
  logic [WW-1:0] w_wcnt_inc;

  assign w_not_empty = (r_count != '0);
  assign w_wcnt_inc  = r_ctl.wcnt + 1'b1;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_ctl.fsm   <= ST_IDLE;
      r_ctl.cause <= CAUSE_NONE;
      r_ctl.wcnt  <= '0;
    end else begin
      r_ctl <= w_ctl_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and datapath controls
  // ---------------------------------------------------------------------------
  always_comb begin
    w_ctl_nxt    = r_ctl;
    w_req        = 1'b0;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_flush      = 1'b0;
    w_load_redir = 1'b0;

    case (r_ctl.fsm)
      // One idle cycle after reset release, so the first request appears one
      // cycle after reset_ni rises.
      ST_IDLE: begin
        w_ctl_nxt.fsm = ST_FETCH;
      end

      ST_FETCH: begin
        // Request only while there is room. This uses the registered count
        // and ignores a pop on the same edge, so a full queue leaves the bus
        // idle for one cycle after a pop.
        w_req = (r_count < FULL);

        if (redirect_i) begin
          // A redirect overrides any ack or pop on the same edge. The ack data
          // is dropped and the bus re-issues at the new target.
          w_flush = 1'b1;
          if (redirect_pc_i[1:0] != 2'b00) begin
            w_ctl_nxt.fsm   = ST_FAULT;
            w_ctl_nxt.cause = CAUSE_MIS;
          end else begin
            w_load_redir   = 1'b1;
            w_ctl_nxt.wcnt = '0;
          end
        end else begin
          w_push = w_req & iack_i;
          w_pop  = w_not_empty & ready_i;

          if (w_push) begin
            w_ctl_nxt.wcnt = '0;
          end else if (w_req && (MAX_WAIT > 0)) begin
            w_ctl_nxt.wcnt = w_wcnt_inc;
            // An ack on the same edge takes the branch above instead, so the
            // ack always wins over the timeout.
            if (w_wcnt_inc == MW) begin
              w_ctl_nxt.fsm   = ST_FAULT;
              w_ctl_nxt.cause = CAUSE_TMO;
              w_flush         = 1'b1;
              w_pop           = 1'b0;
            end
          end
        end
      end

      // Terminal until reset. All inputs are ignored and the cause stays at
      // its first value.
      ST_FAULT: begin
        w_ctl_nxt = r_ctl;
      end

      default: begin
        w_ctl_nxt.fsm = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Fetch PC, queue pointers and occupancy
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_fpc   <= RV;
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
      if (w_load_redir) begin
        r_fpc <= redirect_pc_i;
      end
    end else begin
      if (w_push) begin
        // Pointers are log2(DEPTH) bits wide, so they wrap on their own.
        r_wptr <= r_wptr + 1'b1;
        r_fpc  <= r_fpc + AW'(4);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_inst_mem[r_wptr] <= idat_i;
      r_pc_mem[r_wptr]   <= r_fpc;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign iadr_o        = r_fpc;
  assign isiz_o        = w_req ? SIZ_WORD : SIZ_IDLE;
  assign valid_o       = w_not_empty;
  assign inst_o        = r_inst_mem[r_rptr];
  assign pc_o          = r_pc_mem[r_rptr];
  assign count_o       = r_count;
  assign fault_o       = (r_ctl.fsm == ST_FAULT);
  assign fault_cause_o = r_ctl.cause;

  // ---------------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------------
  a_isiz_legal: assert property (@(posedge clk_i) disable iff (!reset_ni)
    (isiz_o == SIZ_IDLE) || (isiz_o == SIZ_WORD));

  a_count_bound: assert property (@(posedge clk_i) disable iff (!reset_ni)
    count_o <= FULL);

  a_fault_sticky: assert property (@(posedge clk_i) disable iff (!reset_ni)
    fault_o |=> (fault_o && $stable(fault_cause_o)));

  a_fault_quiet: assert property (@(posedge clk_i) disable iff (!reset_ni)
    fault_o |-> (!valid_o && (isiz_o == SIZ_IDLE)));

endmodule

// File: tb/tb_polaris_ifetch.sv
// -----------------------------------------------------------------------------
// tb_polaris_ifetch -- bench for polaris_ifetch.
//
// Three instances share one clock, one reset and one stimulus stream:
//   g_m[0] : AW=64, DEPTH=4, MAX_WAIT=0
//   g_m[1] : AW=64, DEPTH=2, MAX_WAIT=3
//   g_m[2] : AW=32, DEPTH=4, MAX_WAIT=0
// Each instance has a queue-based reference model. A compare process checks
// every output against that model on each falling edge. The directed sequence
// also checks hand-computed literals 1 ns after the rising edges. Inputs
// change 1 ns after a rising edge.
// -----------------------------------------------------------------------------
module tb_polaris_ifetch;

  localparam logic [63:0] RV = 64'hFFFF_FFFF_FFFF_FF00;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        iack  = 1'b0;
  logic        ready = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] idat  = '0;
  logic [63:0] rpc   = '0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // DUTs, reference models and the per-cycle compare
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < 3; g++) begin : g_m
    localparam int AWG = (g == 2) ? 32 : 64;
    localparam int DG  = (g == 1) ? 2 : 4;
    localparam int MWG = (g == 1) ? 3 : 0;
    localparam int CW  = $clog2(DG) + 1;
    localparam logic [63:0] MASK = (AWG == 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                                               : 64'h0000_0000_FFFF_FFFF;

    logic [AWG-1:0] iadr;
    logic [AWG-1:0] pc;
    logic [1:0]     isiz;
    logic [1:0]     cause;
    logic [31:0]    inst;
    logic           valid;
    logic           flt;
    logic [CW-1:0]  cnt;

    polaris_ifetch #(
      .AW           (AWG),
      .DEPTH        (DG),
      .RESET_VECTOR (RV),
      .MAX_WAIT     (MWG)
    ) u_dut (
      .clk_i         (clk),
      .reset_ni      (rst_n),
      .iadr_o        (iadr),
      .isiz_o        (isiz),
      .iack_i        (iack),
      .idat_i        (idat),
      .inst_o        (inst),
      .pc_o          (pc),
      .valid_o       (valid),
      .ready_i       (ready),
      .redirect_i    (redir),
      .redirect_pc_i (rpc[AWG-1:0]),
      .count_o       (cnt),
      .fault_o       (flt),
      .fault_cause_o (cause)
    );

    // Model: queue entries are {inst, pc}. m_run is set once the first cycle
    // after reset has passed, and m_flt marks a halted fetch.
    logic [95:0] q[$];
    logic        m_run;
    logic        m_flt;
    logic [1:0]  m_cause;
    logic [63:0] m_pc;
    int          m_wait;
    logic        m_req;
    logic        m_ack;
    logic        m_pop;

    initial begin
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
          q.delete();
          m_run   = 1'b0;
          m_flt   = 1'b0;
          m_cause = 2'b00;
          m_pc    = RV & MASK;
          m_wait  = 0;
        end else if (m_flt) begin
          m_run = 1'b1;
        end else if (!m_run) begin
          m_run = 1'b1;
        end else begin
          m_req = (q.size() < DG);
          m_ack = m_req && iack;
          m_pop = (q.size() > 0) && ready;
          if (redir) begin
            q.delete();
            if (rpc[1:0] != 2'b00) begin
              m_flt   = 1'b1;
              m_cause = 2'b10;
            end else begin
              m_pc   = rpc & MASK;
              m_wait = 0;
            end
          end else begin
            if (m_pop) void'(q.pop_front());
            if (m_ack) begin
              q.push_back({idat, m_pc});
              m_pc   = (m_pc + 64'd4) & MASK;
              m_wait = 0;
            end else if (m_req) begin
              m_wait++;
              if (MWG > 0 && m_wait == MWG) begin
                m_flt   = 1'b1;
                m_cause = 2'b01;
                q.delete();
              end
            end
          end
        end
      end
    end

    initial begin
      forever begin
        @(negedge clk);
        chk($sformatf("d%0d_isiz", g), 64'(isiz),
            (m_run && !m_flt && q.size() < DG) ? 64'd2 : 64'd0);
        chk($sformatf("d%0d_iadr", g), 64'(iadr), m_pc);
        chk($sformatf("d%0d_valid", g), 64'(valid), 64'(q.size() > 0));
        chk($sformatf("d%0d_count", g), 64'(cnt), 64'(q.size()));
        chk($sformatf("d%0d_fault", g), 64'(flt), 64'(m_flt));
        chk($sformatf("d%0d_cause", g), 64'(cause), 64'(m_cause));
        if (q.size() > 0) begin
          chk($sformatf("d%0d_inst", g), 64'(inst), 64'(q[0][95:64]));
          chk($sformatf("d%0d_pc", g), 64'(pc), q[0][63:0]);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic a, input logic r, input logic rd, input logic [63:0] p);
    iack  = a;
    ready = r;
    redir = rd;
    rpc   = p;
    idat  = $urandom;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence followed by random traffic
  // ---------------------------------------------------------------------------
  initial begin
    // 1: reset, three request cycles without ack, then the first ack.
    tick();
    tick();
    chk("t1_rst_isiz",  64'(g_m[0].isiz),  64'd0);
    chk("t1_rst_iadr",  64'(g_m[0].iadr),  RV);
    chk("t1_rst_valid", 64'(g_m[0].valid), 64'd0);
    chk("t1_rst_cnt",   64'(g_m[0].cnt),   64'd0);
    chk("t1_rst_iadr32", 64'(g_m[2].iadr), 64'hFFFF_FF00);
    rst_n = 1'b1;
    tick();
    chk("t1_req_isiz", 64'(g_m[0].isiz), 64'd2);
    chk("t1_req_iadr", 64'(g_m[0].iadr), RV);
    tick();
    tick();
    chk("t1_hold_iadr", 64'(g_m[0].iadr), RV);
    iack = 1'b1;
    idat = 32'h0000_0013;
    tick();
    chk("t1_valid", 64'(g_m[0].valid), 64'd1);
    chk("t1_inst",  64'(g_m[0].inst),  64'h13);
    chk("t1_pc",    64'(g_m[0].pc),    RV);
    chk("t1_iadr",  64'(g_m[0].iadr),  64'hFFFF_FFFF_FFFF_FF04);

    // 2: fill to DEPTH, then pop once.
    for (int i = 0; i < 3; i++) begin
      idat = $urandom;
      tick();
    end
    chk("t2_full_cnt",  64'(g_m[0].cnt),  64'd4);
    chk("t2_full_isiz", 64'(g_m[0].isiz), 64'd0);
    chk("t2_full_pc",   64'(g_m[0].pc),   RV);
    tick();
    chk("t2_still_cnt", 64'(g_m[0].cnt), 64'd4);
    ready = 1'b1;
    tick();
    chk("t2_pop_cnt",  64'(g_m[0].cnt),  64'd3);
    chk("t2_pop_pc",   64'(g_m[0].pc),   64'hFFFF_FFFF_FFFF_FF04);
    chk("t2_re_isiz",  64'(g_m[0].isiz), 64'd2);
    chk("t2_re_iadr",  64'(g_m[0].iadr), 64'hFFFF_FFFF_FFFF_FF10);
    ready = 1'b0;
    tick();

    // 3: two entries left, then redirect with an ack and a pop on the same edge.
    set_in(1'b0, 1'b1, 1'b0, 64'd0);
    tick();
    tick();
    chk("t3_cnt2", 64'(g_m[0].cnt), 64'd2);
    set_in(1'b1, 1'b1, 1'b1, 64'h124);
    tick();
    chk("t3_rd_cnt",   64'(g_m[0].cnt),   64'd0);
    chk("t3_rd_valid", 64'(g_m[0].valid), 64'd0);
    chk("t3_rd_iadr",  64'(g_m[0].iadr),  64'h124);
    chk("t3_rd_isiz",  64'(g_m[0].isiz),  64'd2);
    set_in(1'b1, 1'b0, 1'b0, 64'd0);
    tick();
    chk("t3_pc", 64'(g_m[0].pc), 64'h124);

    // 4: misaligned redirect, then ignored traffic, then reset.
    set_in(1'b1, 1'b0, 1'b1, 64'h126);
    tick();
    chk("t4_fault", 64'(g_m[0].flt),   64'd1);
    chk("t4_cause", 64'(g_m[0].cause), 64'd2);
    chk("t4_isiz",  64'(g_m[0].isiz),  64'd0);
    for (int i = 0; i < 8; i++) begin
      set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             {$urandom, $urandom} & ~64'd3);
      tick();
    end
    chk("t4_hold_fault", 64'(g_m[0].flt),   64'd1);
    chk("t4_hold_cause", 64'(g_m[0].cause), 64'd2);
    chk("t4_hold_cnt",   64'(g_m[0].cnt),   64'd0);
    set_in(1'b0, 1'b0, 1'b0, 64'd0);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_fault", 64'(g_m[0].flt),   64'd0);
    chk("t4_rst_cause", 64'(g_m[0].cause), 64'd0);
    chk("t4_rst_iadr",  64'(g_m[0].iadr),  RV);

    // 5: timeout on instance 1 (MAX_WAIT=3), then the ack-wins case.
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    chk("t5_pre_fault", 64'(g_m[1].flt), 64'd0);
    tick();
    chk("t5_tmo_fault", 64'(g_m[1].flt),   64'd1);
    chk("t5_tmo_cause", 64'(g_m[1].cause), 64'd1);
    chk("t5_tmo_isiz",  64'(g_m[1].isiz),  64'd0);
    chk("t5_nomw_fault", 64'(g_m[0].flt),  64'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    iack = 1'b1;
    tick();
    chk("t5_ack_fault", 64'(g_m[1].flt),   64'd0);
    chk("t5_ack_valid", 64'(g_m[1].valid), 64'd1);
    iack = 1'b0;
    tick();
    chk("t5_after_fault", 64'(g_m[1].flt), 64'd0);

    // 6: address wrap on the 32-bit instance, then continuous push/pop.
    set_in(1'b1, 1'b0, 1'b1, 64'h0000_0000_FFFF_FFFC);
    tick();
    set_in(1'b1, 1'b0, 1'b0, 64'd0);
    tick();
    chk("t6_pc0",    64'(g_m[2].pc),    64'hFFFF_FFFC);
    chk("t6_valid0", 64'(g_m[2].valid), 64'd1);
    tick();
    set_in(1'b1, 1'b1, 1'b0, 64'd0);
    tick();
    chk("t6_pc1",  64'(g_m[2].pc),  64'h0);
    chk("t6_cnt2", 64'(g_m[2].cnt), 64'd2);
    set_in(1'b0, 1'b1, 1'b0, 64'd0);
    tick();
    for (int i = 0; i < 20; i++) begin
      set_in(1'b1, 1'b1, 1'b0, 64'd0);
      tick();
      chk("t6_wrap_cnt", 64'(g_m[2].cnt), 64'd1);
    end

    // 7: random traffic with occasional redirects and resets.
    for (int i = 0; i < 600; i++) begin
      iack  = ($urandom_range(0, 99) < 65);
      ready = ($urandom_range(0, 99) < 55);
      idat  = $urandom;
      redir = ($urandom_range(0, 99) < 5);
      rpc   = {$urandom, $urandom};
      if ($urandom_range(0, 7) != 0) rpc[1:0] = 2'b00;
      if ($urandom_range(0, 5) == 0) rpc[63:32] = 32'hFFFF_FFFF;
      rst_n = ($urandom_range(0, 99) >= 3);
      tick();
    end
    rst_n = 1'b1;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/polaris_ifetch.md
Name: polaris_ifetch

Overview:
- Parametrised instruction-fetch front end for the Polaris RV64 core.
- Replaces the single-word fetch with a prefetching I-bus master feeding a DEPTH-entry instruction queue.
- Supports redirects (jumps/traps) with queue flush.
- Replaces the CPU's jam-on-bad-state behaviour with a sticky, cause-coded fault for bus timeout or misaligned redirect.

Parameters:
AW, 64, address width of iadr_o, pc_o and redirect_pc_i (32..64).
DEPTH, 4, instruction queue entries; power of two, 2..16.
RESET_VECTOR, 64'hFFFF_FFFF_FFFF_FF00, first fetch address after reset; only AW LSBs used.
MAX_WAIT, 0, consecutive un-acked request cycles before bus-timeout fault; 0 disables timeout.

Ports:
clk_i  in  1  system clock; all state changes on rising edge.
reset_ni  in  1  asynchronous, active-low reset.
iadr_o  out  AW  I-bus fetch address.
isiz_o  out  2  I-bus request size: 00 idle, 10 32-bit word; 01/11 never driven.
iack_i  in  1  I-bus acknowledge; transfer completes on a rising edge with isiz_o=10 and iack_i=1.
idat_i  in  32  I-bus read data, valid with iack_i.
inst_o  out  32  instruction at queue head.
pc_o  out  AW  address of inst_o.
valid_o  out  1  queue head valid.
ready_i  in  1  consumer accepts head; pop when valid_o & ready_i.
redirect_i  in  1  flush queue and restart fetch at redirect_pc_i.
redirect_pc_i  in  AW  redirect target.
count_o  out  clog2(DEPTH)+1  queue occupancy.
fault_o  out  1  sticky fault; fetch halted.
fault_cause_o  out  2  00 none, 01 bus timeout, 10 misaligned redirect.

Behaviour:
- Reset (reset_ni=0, async):
  - FSM=IDLE; fetch PC=RESET_VECTOR; queue empty.
  - isiz_o=00, iadr_o=RESET_VECTOR, valid_o=0, count_o=0, fault_o=0, fault_cause_o=00, wait counter=0.
- FSM states IDLE, FETCH, FAULT.
  - IDLE -> FETCH on the first rising edge after reset_ni deasserts, so isiz_o=10 one cycle after release.
  - FETCH -> FAULT on a fault condition.
  - FAULT holds until reset.
- Request issue:
  - isiz_o=10 iff state=FETCH and count_o<DEPTH; otherwise 00.
  - iadr_o = fetch PC at all times.
  - Request held stable until acked; no lookahead on a same-cycle pop, so a full queue idles the bus one cycle after a pop.
- Ack at edge N:
  - Entry {idat_i, fetch PC} pushed at tail; fetch PC += 4, wrapping modulo 2^AW.
  - valid_o/inst_o/pc_o reflect the entry from cycle N+1 when the queue was empty (no bypass).
- Push and pop in the same edge: count unchanged; pointers wrap modulo DEPTH.
- Pop with empty queue is impossible: valid_o=0 forbids it.
- Redirect (state=FETCH, redirect_pc_i[1:0]=00) at edge N:
  - Queue emptied; any same-cycle ack data discarded; same-cycle pop ignored.
  - Fetch PC = redirect_pc_i; wait counter cleared.
  - Cycle N+1: valid_o=0, count_o=0, isiz_o=10, iadr_o=redirect_pc_i.
- Redirect with redirect_pc_i[1:0]!=00:
  - Enter FAULT with cause 10; queue emptied.
- Timeout (MAX_WAIT>0):
  - Wait counter increments each edge with isiz_o=10 & iack_i=0; cleared on ack or redirect.
  - Reaching MAX_WAIT enters FAULT with cause 01.
  - An ack on the same edge wins: no fault.
- FAULT state:
  - isiz_o=00, valid_o=0, count_o=0; iack_i, redirect_i, ready_i ignored.
  - fault_o=1; cause frozen at its first value.
- Reset asserted mid-transfer or mid-fault: immediate return to reset values; no pending ack is honoured.
- Outputs inst_o/pc_o are don't-care when valid_o=0; bench must not check them.

Test Plan:
1. Release reset with iack_i=0 for 3 cycles, then ack idat_i=32'h0000_0013:
   - isiz_o=00 in reset, then 10 with iadr_o=FFFF_FFFF_FFFF_FF00 until ack.
   - Next cycle valid_o=1, inst_o=0000_0013, pc_o=..FF00; iadr_o=..FF04.
2. iack_i=1 continuously, ready_i=0, DEPTH=4:
   - Four pushes, count_o=4, isiz_o=00; pc_o stays ..FF00.
   - ready_i=1 for one cycle: count_o=3, pc_o=..FF04.
   - Next cycle isiz_o=10 at iadr_o=..FF10.
3. Queue holds 2 entries, redirect_i=1 to 0000_0124 on the same edge as an ack and a pop:
   - Next cycle count_o=0, valid_o=0, iadr_o=0000_0000_0000_0124.
   - Following ack yields pc_o=..0124.
4. Redirect to 0000_0000_0000_0126:
   - fault_o=1, fault_cause_o=10, isiz_o=00 permanently.
   - Later redirects and acks are ignored; reset clears the fault.
5. MAX_WAIT=3, iack_i held low:
   - Fault cause 01 on the 3rd un-acked edge.
   - Repeat with an ack on the 3rd edge: no fault.
6. AW=32, redirect to FFFF_FFFC, ack twice:
   - pc_o sequence FFFF_FFFC then 0000_0000.
   - Pointer wrap exercised by continuous push/pop for 20 cycles with count_o stable at 1.
